uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares a single UART transmitter (`UART_top` transmit path) between `NREQ` requesters. It accepts one frame at a time from a requester, drives the transmitter's `tx_start`/`din` handshake, and waits for `tx_done` before granting the next requester. It sits between client logic and `UART_top`. Baud configuration (`br_div`) passes straight through and is not handled here.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 3: frame data width; matches the transmitter `din` width.
- `TO_CYCLES`, 200000: watchdog limit in clk cycles. Used only when `UART_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  requester i has a frame pending; held high until `ack[i]`.
- `data`  in  NREQ*DW  packed frames; requester i at `[i*DW +: DW]`.
- `ack`  out  NREQ  one-cycle pulse: frame of requester i committed.
- `done`  out  NREQ  one-cycle pulse: requester i's frame fully transmitted.
- `tx_start`  out  1  to `UART_top`; one-cycle start pulse.
- `din`  out  DW  to `UART_top`; frame data.
- `tx_done`  in  1  from `UART_top`; end-of-frame pulse.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  $clog2(NREQ)  index of the current or last granted requester.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE: if `req != 0`, choose the first set bit scanning from `last_grant+1` upward, with wrap-around.
  - Latch `din <= data[sel]` and `owner <= sel`.
  - Go to START.
- START, exactly one cycle:
  - `tx_start = 1` and `ack[owner] = 1`.
  - Go to WAIT.
  - Once START is entered, the frame is committed even if `req` drops.
- WAIT: hold `din` and `owner` stable.
  - On `tx_done`: pulse `done[owner]`, set `last_grant <= owner`, go to IDLE.
- `tx_done` in IDLE or START is ignored: no `done` pulse, no state change.
- A requester that drops `req` while in IDLE, before being selected, is skipped. No error is raised.
- A requester that keeps `req` high after `ack` is treated as having a new frame. It competes again in the next IDLE under round-robin rules.
- Outputs `tx_start`, `ack`, `done`, `busy` and `timeout_err` are decoded from registered state only. None is a combinational function of an input.

## Timing
- Reset (`rst = 0`), applied asynchronously:
  - State IDLE.
  - `din = 0`, `owner = 0`, `last_grant = NREQ-1`, so requester 0 has first priority.
  - All outputs 0.
- Reset mid-frame: same values. The transmitter is not notified.
- Latency:
  - `req` sampled high at edge k → `tx_start` and `ack` high for the cycle after edge k.
  - `tx_done` sampled at edge m → `done` high for the cycle after edge m; IDLE from edge m.
  - Minimum spacing from `tx_done` to the next `tx_start` is 2 cycles.
- `din` is stable from the `tx_start` cycle through the `tx_done` cycle.
- Simultaneous requests are granted strictly round-robin. With all requesters active, each is served once per NREQ frames.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TO_CYCLES` with no `tx_done`: pulse `timeout_err` for 1 cycle, do not pulse `done`, set `last_grant <= owner`, go to IDLE.
  - A `tx_done` arriving on the same edge as expiry wins: normal completion, no error.
- Not defined: no counter. WAIT persists until `tx_done`, and `timeout_err` is tied to 0.

## Test plan
- Single request: release reset, `req = 4'b0001`, `data[2:0] = 5` → `tx_start` and `ack[0]` 1 cycle later with `din = 5`. Pulse `tx_done` 500 cycles later → `done[0]` next cycle, `busy = 0`.
- All four requesters with data 1, 2, 3, 4, held after ack → grant order 0, 1, 2, 3, 0. `din` values 1, 2, 3, 4, 1. Each `tx_start` is ≥2 cycles after the previous `tx_done`.
- `req[0]` and `req[2]` permanently high → owners alternate 0, 2, 0, 2. `ack[1]` and `ack[3]` never assert.
- `tx_done` pulsed while IDLE and during START → no `done`, and the frame still waits for a later `tx_done`.
- Assert `rst` low during WAIT with owner 2 → all outputs 0 immediately. After release with `req = 4'b1111`, the first grant is owner 0.
- With `UART_ARB_TIMEOUT_EN` and `TO_CYCLES = 100`: grant requester 1, never pulse `tx_done` → `timeout_err` pulses 100 cycles after WAIT entry, no `done[1]`, and the next pending requester (2) is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit path between NREQ requesters.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 3,
   parameter int unsigned TO_CYCLES = 200000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DW-1:0]        data,
   output logic [NREQ-1:0]           ack,
   output logic [NREQ-1:0]           done,
   output logic                      tx_start,
   output logic [DW-1:0]             din,
   input  logic                      tx_done,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      timeout_err
);

   localparam int unsigned OW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t          state;
   logic [OW-1:0]   last_grant;
   logic [OW-1:0]   sel;
   logic [OW-1:0]   cand_idx;
   logic            hit;
   int unsigned     cand;
   logic [DW-1:0]   frame [NREQ];

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         frame[i] = data[i*DW +: DW];
      end
   end

   // Scan upward from the slot after the last grant, wrapping at NREQ.
   always_comb begin
      sel      = '0;
      hit      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = 32'(last_grant) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = OW'(cand);
         if (!hit && req[cand_idx]) begin
            hit = 1'b1;
            sel = cand_idx;
         end
      end
   end

   assign busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         din         <= '0;
         owner       <= '0;
         last_grant  <= OW'(NREQ - 1);
         ack         <= '0;
         done        <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
      end else begin
         ack         <= '0;
         done        <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (hit) begin
                  din      <= frame[sel];
                  owner    <= sel;
                  tx_start <= 1'b1;
                  ack      <= NREQ'(1) << sel;
                  state    <= START;
               end
            end
            START: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // tx_done on the expiry edge takes priority over the watchdog.
               if (tx_done) begin
                  done       <= NREQ'(1) << owner;
                  last_grant <= owner;
                  state      <= IDLE;
               end else if (cnt == CW'(TO_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  last_grant  <= owner;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic unused_to_cycles;
   assign unused_to_cycles = (TO_CYCLES == 0);
   assign timeout_err      = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         din        <= '0;
         owner      <= '0;
         last_grant <= OW'(NREQ - 1);
         ack        <= '0;
         done       <= '0;
         tx_start   <= 1'b0;
      end else begin
         ack      <= '0;
         done     <= '0;
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (hit) begin
                  din      <= frame[sel];
                  owner    <= sel;
                  tx_start <= 1'b1;
                  ack      <= NREQ'(1) << sel;
                  state    <= START;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (tx_done) begin
                  done       <= NREQ'(1) << owner;
                  last_grant <= owner;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: driver queues expected grants/completions,
// a negedge monitor pops and compares. Timeout scenario runs when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 3;
   localparam int TO   = 100;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   data = '0;
   logic [NREQ-1:0]      ack, done;
   logic                 tx_start, busy, timeout_err;
   logic                 tx_done = 1'b0;
   logic [DW-1:0]        din;
   logic [1:0]           owner;

   typedef struct {
      int            owner;
      logic [DW-1:0] din;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   errors = 0;
   int   checks = 0;
   int   model_last = NREQ - 1;
   int   cur_sel = 0;

   int            cyc = 0;
   int            done_cyc = 0;
   bit            seen_done = 0;
   bit            in_frame = 0;
   bit            stable = 1;
   logic [DW-1:0] frame_din = '0;
   int            to_seen = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TO_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .done(done),
      .tx_start(tx_start), .din(din), .tx_done(tx_done), .busy(busy),
      .owner(owner), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Reference: first pending requester after the last grant, wrapping around.
   function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (last + k) % NREQ;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   o;
      cyc++;
      if (!rst) begin
         in_frame = 0;
      end else begin
         if (done != '0) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: done=%b, required no pulse", done);
            end else begin
               o = done_q.pop_front();
               if (done !== 4'(1 << o) || owner !== 2'(o) || busy !== 1'b0 || !stable || din !== frame_din) begin
                  errors++;
                  $display("FAIL done_pulse: done=%b owner=%0d busy=%b din_stable=%0d din=%0d, required done=%b owner=%0d busy=0 din_stable=1 din=%0d",
                           done, owner, busy, stable, din, 4'(1 << o), o, frame_din);
               end
            end
            in_frame  = 0;
            done_cyc  = cyc;
            seen_done = 1;
         end
         if (timeout_err) begin
            to_seen++;
            in_frame = 0;
         end
         if (in_frame && din !== frame_din) stable = 0;
         if (tx_start) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL start_unexpected: tx_start=1 owner=%0d, required no grant", owner);
            end else begin
               e = exp_q.pop_front();
               if (owner !== 2'(e.owner) || din !== e.din || ack !== 4'(1 << e.owner) || busy !== 1'b1 ||
                   (seen_done && (cyc - done_cyc) < 1)) begin
                  errors++;
                  $display("FAIL grant: owner=%0d din=%0d ack=%b busy=%b gap=%0d, required owner=%0d din=%0d ack=%b busy=1 gap>=1",
                           owner, din, ack, busy, cyc - done_cyc, e.owner, e.din, 4'(1 << e.owner));
               end
            end
            in_frame  = 1;
            frame_din = din;
            stable    = 1;
         end else if (ack != '0) begin
            checks++;
            errors++;
            $display("FAIL stray_ack: ack=%b without tx_start, required 0000", ack);
         end
      end
   end

   task automatic check_idle_outputs(input string name);
      checks++;
      if (ack !== '0 || done !== '0 || tx_start !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: ack=%b done=%b tx_start=%b busy=%b timeout_err=%b, required all 0",
                  name, ack, done, tx_start, busy, timeout_err);
      end
   endtask

   task automatic check_reset_state(input string name);
      check_idle_outputs(name);
      checks++;
      if (owner !== 2'd0 || din !== '0) begin
         errors++;
         $display("FAIL %s_regs: owner=%0d din=%0d, required owner=0 din=0", name, owner, din);
      end
   endtask

   task automatic issue(input logic [NREQ-1:0] mask);
      exp_t e;
      int   s;
      s       = rr_pick(mask, model_last);
      e.owner = s;
      e.din   = data[s*DW +: DW];
      exp_q.push_back(e);
      cur_sel = s;
      req     = mask;
   endtask

   task automatic wait_ack();
      bit got;
      got = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (ack != '0) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_wait: ack=%b after 4 cycles, required a grant", ack);
      end
   endtask

   task automatic finish_frame(input int wait_cyc);
      repeat (wait_cyc) begin
         @(posedge clk); #1;
      end
      done_q.push_back(cur_sel);
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done    = 1'b0;
      model_last = cur_sel;
      req        = '0;
   endtask

   task automatic do_frame(input logic [NREQ-1:0] mask, input int wait_cyc, input bit start_glitch, input bit junk);
      issue(mask);
      wait_ack();
      if (start_glitch) begin
         tx_done = 1'b1;
         @(posedge clk); #1;
         tx_done = 1'b0;
      end
      if (junk) req = 4'($urandom);
      finish_frame(wait_cyc);
   endtask

   task automatic gap(input int n, input bit idle_glitch);
      req     = '0;
      tx_done = idle_glitch;
      @(posedge clk); #1;
      tx_done = 1'b0;
      check_idle_outputs("idle_gap");
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at 2ms, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check_reset_state("reset_state");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_reset_state("after_release");

      // All four held: expected grant order 0,1,2,3,0 with data 1,2,3,4,1.
      data = {3'd4, 3'd3, 3'd2, 3'd1};
      for (int i = 0; i < 5; i++) do_frame(4'b1111, 2 + i, 1'b0, 1'b0);
      gap(2, 1'b0);

      // Requesters 0 and 2 only: owners alternate, 1 and 3 never acked.
      data = 12'($urandom);
      for (int i = 0; i < 4; i++) do_frame(4'b0101, 3, 1'b0, 1'b0);
      gap(2, 1'b1);

      // Single request with long transmission.
      data      = '0;
      data[2:0] = 3'd5;
      do_frame(4'b0001, 500, 1'b0, 1'b0);
      gap(1, 1'b0);

      // tx_done during START and in IDLE must be ignored.
      data = 12'($urandom);
      do_frame(4'b1000, 4, 1'b1, 1'b0);
      gap(3, 1'b1);

      for (int i = 0; i < 40; i++) begin
         data = 12'($urandom);
         do_frame(4'($urandom_range(1, 15)), $urandom_range(1, 20), ($urandom_range(0, 3) == 0), 1'b1);
         if ($urandom_range(0, 2) != 0) gap($urandom_range(0, 3), ($urandom_range(0, 2) == 0));
      end
      gap(1, 1'b0);

      // Reset while requester 2 is in WAIT.
      data = 12'($urandom);
      issue(4'b0100);
      wait_ack();
      repeat (3) begin
         @(posedge clk); #1;
      end
      #1 rst = 1'b0;
      req = '0;
      #1;
      check_reset_state("reset_mid_frame");
      model_last = NREQ - 1;
      @(posedge clk);
      @(posedge clk); #1;
      rst  = 1'b1;
      data = 12'($urandom);
      do_frame(4'b1111, 3, 1'b0, 1'b0);
      gap(1, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
      begin
         int n;
         data = 12'($urandom);
         issue(4'b0110);
         wait_ack();
         req = 4'b0100;
         n   = 0;
         for (int k = 1; k <= TO + 20; k++) begin
            @(posedge clk); #1;
            if (timeout_err) begin
               n = k;
               break;
            end
         end
         checks++;
         if (n != TO + 1 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expiry: cycles=%0d done=%b busy=%b, required cycles=%0d done=0000 busy=0",
                     n, done, busy, TO + 1);
         end
         model_last = cur_sel;
         issue(4'b0100);
         wait_ack();
         req = '0;
         finish_frame(2);
         gap(1, 1'b0);
      end
`endif

      repeat (2) @(posedge clk);
      #1;
      checks++;
`ifdef UART_ARB_TIMEOUT_EN
      if (to_seen != 1) begin
         errors++;
         $display("FAIL timeout_count: pulses=%0d, required 1", to_seen);
      end
`else
      if (to_seen != 0) begin
         errors++;
         $display("FAIL timeout_count: pulses=%0d, required 0", to_seen);
      end
`endif
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: pending grants=%0d completions=%0d, required 0 and 0",
                  exp_q.size(), done_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
